// File: rtl/nibble_serial_add_seq.sv
// Serial multi-nibble adder sequencer driving an external 4-bit ripple-carry slice, LS nibble first.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVERFLOW_EN.
module nibble_serial_add_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [3:0]       slice_a,
    output logic [3:0]       slice_b,
    output logic             slice_cin,
    input  logic [3:0]       slice_sum,
    input  logic             slice_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef SERIAL_ADD_OVERFLOW_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic             last_nibble;

    // Shift registers empty themselves after the last nibble, so slice
    // operands read straight from them are zero outside RUN.
    assign slice_a     = a_sr[3:0];
    assign slice_b     = b_sr[3:0];
    assign slice_cin   = carry;
    assign last_nibble = (cnt == CNT_W'(NIBBLES - 1));

    // Sequencer state, operand shifters and result assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            cnt       <= '0;
            carry     <= 1'b0;
            a_sr      <= '0;
            b_sr      <= '0;
`ifdef SERIAL_ADD_OVERFLOW_EN
            out_ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr     <= in_a;
                        b_sr     <= in_b;
                        carry    <= in_cin;
                        out_sum  <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    out_sum[{cnt, 2'b00} +: 4] <= slice_sum;
                    a_sr <= a_sr >> 4;
                    b_sr <= b_sr >> 4;
                    if (last_nibble) begin
                        out_cout  <= slice_cout;
`ifdef SERIAL_ADD_OVERFLOW_EN
                        // Carry into the MSB recovered from the slice's MSB sum bit.
                        out_ovf   <= slice_a[3] ^ slice_b[3] ^ slice_sum[3] ^ slice_cout;
`endif
                        carry     <= 1'b0;
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        carry <= slice_cout;
                        cnt   <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_seq.sv
// Bench for nibble_serial_add_seq (WIDTH=16) with a behavioural 4-bit ripple-carry slice.
// Define SERIAL_ADD_OVERFLOW_EN to also check out_ovf.
module tb_nibble_serial_add_seq;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned NIBBLES = WIDTH / 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic [3:0]       slice_a;
    logic [3:0]       slice_b;
    logic             slice_cin;
    logic [3:0]       slice_sum;
    logic             slice_cout;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
`ifdef SERIAL_ADD_OVERFLOW_EN
    logic             out_ovf;
`endif

    nibble_serial_add_seq #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_cin     (in_cin),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_sum  (slice_sum),
        .slice_cout (slice_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_cout   (out_cout)
`ifdef SERIAL_ADD_OVERFLOW_EN
        ,
        .out_ovf    (out_ovf)
`endif
    );

    // External combinational 4-bit adder slice.
    logic [4:0] slice_res;
    assign slice_res  = 5'(slice_a) + 5'(slice_b) + 5'(slice_cin);
    assign slice_sum  = slice_res[3:0];
    assign slice_cout = slice_res[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        int          hold;
    } vec_t;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[9];
    int   checks;
    int   failures;
    logic [3:0] last_trace;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic run_add(input logic [15:0] a, input logic [15:0] b, input logic cin,
                           input logic [15:0] esum, input logic ecout, input int hold);
        int          n;
        logic [3:0]  trace;
        logic [15:0] held;
        logic [16:0] wide;
        exp_t        e;
        exp_t        got;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", 32'(in_ready), 32'd1);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        @(posedge clk);
        wide  = 17'(a) + 17'(b) + 17'(cin);
        e.sum  = esum;
        e.cout = ecout;
        e.ovf  = (a[15] == b[15]) && (wide[15] != a[15]);
        sb.push_back(e);
        #1 in_valid = 1'b0;
        n     = 0;
        trace = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) break;
            if (n < 4) trace[n] = slice_cin;
            n++;
        end
        chk("latency", 32'(n), 32'(NIBBLES));
        last_trace = trace;
        held = out_sum;
        for (int k = 0; k < hold; k++) begin
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_slice_zero", 32'({slice_a, slice_b, slice_cin}), 32'd0);
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_sum_stable", 32'(out_sum), 32'(held));
        end
        out_ready = 1'b1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            got = sb.pop_front();
            chk("sum", 32'(out_sum), 32'(got.sum));
            chk("cout", 32'(out_cout), 32'(got.cout));
`ifdef SERIAL_ADD_OVERFLOW_EN
            chk("ovf", 32'(out_ovf), 32'(got.ovf));
`endif
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("valid_fall", 32'(out_valid), 32'd0);
        chk("bubble_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        checks     = 0;
        failures   = 0;
        last_trace = '0;
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0};
        vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 0};
        vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 0};
        vecs[4] = '{16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 5};
        vecs[5] = '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0, 1};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 0};
        vecs[7] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 0};
        vecs[8] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 0};

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_cout", 32'(out_cout), 32'd0);
        chk("rst_slice", 32'({slice_a, slice_b, slice_cin}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_add(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].hold);
            if (i == 1) chk("carry_chain_trace", 32'(last_trace), 32'b1110);
        end

        // Asynchronous reset two edges into RUN.
        @(negedge clk);
        in_a     = 16'hAAAA;
        in_b     = 16'h5555;
        in_cin   = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("mid_run_busy", 32'(in_ready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_sum", 32'(out_sum), 32'd0);
        chk("arst_out_cout", 32'(out_cout), 32'd0);
        chk("arst_slice", 32'({slice_a, slice_b, slice_cin}), 32'd0);
`ifdef SERIAL_ADD_OVERFLOW_EN
        chk("arst_out_ovf", 32'(out_ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        run_add(16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 0);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
